// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI link (master and slave ends).
//   - spi_state_e     : slave frame FSM states
//   - SPI_DATA_WIDTH  : default bits per frame
//   - SPI_SYNC_STAGES : default synchronizer depth for pin inputs
//   - SPI_CPOL/CPHA   : the single SPI mode both ends agree on (mode 0)
//   - spi_cnt_width() : width of a bit counter that must reach DATA_WIDTH
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam int SPI_DATA_WIDTH  = 8;
    localparam int SPI_SYNC_STAGES = 2;

    // Mode 0: SCLK idles low, data is sampled on the leading (rising) edge
    // and changed on the trailing (falling) edge, MSB first.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_IDLE     = 2'd1,
        ST_ACTIVE   = 2'd2
    } spi_state_e;

    // The bit counter has to hold the value DATA_WIDTH itself, not just
    // DATA_WIDTH-1, because the full count marks the byte boundary.
    function automatic int spi_cnt_width(input int data_width);
        return $clog2(data_width + 1);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Brings one asynchronous pin into the clk domain through a flop chain and
// produces single-cycle rise/fall strobes from the synchronized level.
// Ports:
//   clk     in  system clock
//   reset   in  synchronous active-high reset (chain and history clear to 0)
//   async_i in  asynchronous pin
//   sync_o  out synchronized level
//   rise_o  out one-cycle strobe on a 0->1 transition of sync_o
//   fall_o  out one-cycle strobe on a 1->0 transition of sync_o
// -----------------------------------------------------------------------------
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    // Fewer than two flops is not a synchronizer; clamp silently.
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    // Clearing to 0 matters for CS: a reset taken while CS is low must not
    // look like "CS already high", otherwise the slave could rejoin a frame
    // that is still running.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign sync_o = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~hist_q;
    assign fall_o = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
// Mode-0 SPI responder. SCLK, CS and MOSI are oversampled in the clk domain
// (clk must be at least 4x SCLK). Received frames are presented on
// slaveDataReceived with a done pulse; the response word is preloaded via
// load/slaveDataToSend and shifted out MSB first on MISO.
// Ports:
//   clk               in   system clock
//   reset             in   synchronous active-high reset
//   SCLK, CS, MOSI    in   SPI pins (asynchronous to clk, CS active low)
//   MISO              out  slave data, released (Z) unless a frame is active
//   slaveDataToSend   in   response word
//   load              in   one-cycle strobe capturing slaveDataToSend
//   slaveDataReceived out  last complete received frame
//   done              out  one-cycle pulse when slaveDataReceived updates
//   busy              out  high while a frame is active
//   aborted           out  one-cycle pulse when CS rises mid-frame
// -----------------------------------------------------------------------------
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  SCLK,
    input  logic                  CS,
    input  logic                  MOSI,
    output logic                  MISO,
    input  logic [DATA_WIDTH-1:0] slaveDataToSend,
    input  logic                  load,
    output logic [DATA_WIDTH-1:0] slaveDataReceived,
    output logic                  done,
    output logic                  busy,
    output logic                  aborted
);

    localparam int                STAGES   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int                CNT_W    = spi_cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    // With CPOL == CPHA the capture edge is the rising SCLK edge.
    localparam logic              SAMPLE_ON_FALL = SPI_CPOL ^ SPI_CPHA;

    // ------------------------------------------------------------------
    // Pin synchronization
    // ------------------------------------------------------------------
    logic sclk_rise;
    logic sclk_fall;
    logic sclk_level_unused;
    logic cs_sync;
    logic cs_rise;
    logic cs_fall;

    spi_sync_edge #(
        .SYNC_STAGES (STAGES)
    ) u_sclk_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (SCLK),
        .sync_o  (sclk_level_unused),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    spi_sync_edge #(
        .SYNC_STAGES (STAGES)
    ) u_cs_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (CS),
        .sync_o  (cs_sync),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    // MOSI only needs its level; it goes through the same number of flops
    // as SCLK so the sampled bit lines up with the detected capture edge.
    logic [STAGES-1:0] mosi_sync_q;
    logic              mosi_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[STAGES-2:0], MOSI};
        end
    end

    assign mosi_sync = mosi_sync_q[STAGES-1];

    logic sample_edge;
    logic shift_edge;

    assign sample_edge = SAMPLE_ON_FALL ? sclk_fall : sclk_rise;
    assign shift_edge  = SAMPLE_ON_FALL ? sclk_rise : sclk_fall;

    // ------------------------------------------------------------------
    // Frame FSM and datapath
    // ------------------------------------------------------------------
    spi_state_e            state_q;
    logic [DATA_WIDTH-1:0] tx_buf_q;
    logic [DATA_WIDTH-1:0] tx_shift_q;
    logic [DATA_WIDTH-1:0] rx_shift_q;
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic                  done_q;
    logic                  aborted_q;
    logic                  load_ok;
    logic [DATA_WIDTH-1:0] tx_reload_d;

    assign load_ok = load && (state_q != ST_DISARMED);

    // A load arriving in the very cycle the shifter reloads must win, so the
    // reload value is forwarded from the input rather than taken from tx_buf_q.
    assign tx_reload_d = load_ok ? slaveDataToSend : tx_buf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_DISARMED;
            tx_buf_q   <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            bit_cnt_q  <= '0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;

            if (load_ok) begin
                tx_buf_q <= slaveDataToSend;
            end

            case (state_q)
                // Stay out of the bus until CS is seen high, so a frame that
                // was already running when reset hit is never joined midway.
                ST_DISARMED: begin
                    if (cs_sync) begin
                        state_q <= ST_IDLE;
                    end
                end

                // A capture edge coinciding with csFall is dropped here on
                // purpose; only csFall is acted upon.
                ST_IDLE: begin
                    if (cs_fall) begin
                        tx_shift_q <= tx_reload_d;
                        bit_cnt_q  <= '0;
                        state_q    <= ST_ACTIVE;
                    end
                end

                ST_ACTIVE: begin
                    if (bit_cnt_q == CNT_FULL) begin
                        // Byte boundary: publish, then rearm for a following
                        // frame with CS still held low.
                        rx_data_q  <= rx_shift_q;
                        done_q     <= 1'b1;
                        bit_cnt_q  <= '0;
                        tx_shift_q <= tx_reload_d;
                    end else if (sample_edge) begin
                        rx_shift_q <= {rx_shift_q[DATA_WIDTH-2:0], mosi_sync};
                        bit_cnt_q  <= bit_cnt_q + CNT_ONE;
                    end else if (shift_edge && (bit_cnt_q != '0)) begin
                        // At count 0 the MSB has not been sampled yet, so the
                        // trailing edge must not advance the shifter.
                        tx_shift_q <= tx_shift_q << 1;
                    end

                    if (cs_rise) begin
                        state_q <= ST_IDLE;
                        // A completed byte still waiting to be published is
                        // not an abort.
                        if ((bit_cnt_q != '0) && (bit_cnt_q != CNT_FULL)) begin
                            aborted_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q <= ST_DISARMED;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign slaveDataReceived = rx_data_q;
    assign done              = done_q;
    assign aborted           = aborted_q;
    assign busy              = (state_q == ST_ACTIVE);
    assign MISO              = (state_q == ST_ACTIVE) ? tx_shift_q[DATA_WIDTH-1] : 1'bz;

endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
// Bench for spi_slave: a mode-0 master model drives the pins at SCLK = clk/8.
// Expected received bytes are queued when a frame is started and popped by a
// monitor whenever done pulses. MISO is observed through a pulled-up net, so
// a released MISO reads as 1.
// -----------------------------------------------------------------------------
module tb_spi_slave;

    logic       clk;
    logic       reset;
    logic       SCLK;
    logic       CS;
    logic       MOSI;
    wire        miso_w;
    logic [7:0] slaveDataToSend;
    logic       load;
    logic [7:0] slaveDataReceived;
    logic       done;
    logic       busy;
    logic       aborted;

    pullup (miso_w);

    spi_slave #(
        .DATA_WIDTH  (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .SCLK              (SCLK),
        .CS                (CS),
        .MOSI              (MOSI),
        .MISO              (miso_w),
        .slaveDataToSend   (slaveDataToSend),
        .load              (load),
        .slaveDataReceived (slaveDataReceived),
        .done              (done),
        .busy              (busy),
        .aborted           (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         tests_run    = 0;
    int         tests_failed = 0;
    int         done_cnt     = 0;
    int         abort_cnt    = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard side: every done pulse must match the oldest queued byte.
    always @(negedge clk) begin
        if (!reset && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_done: got rx %02h, expected no done", slaveDataReceived);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                $display("[TB] done rx=%02h expected=%02h", slaveDataReceived, e);
                check("rx_on_done", {24'h0, slaveDataReceived}, {24'h0, e});
            end
        end
        if (!reset && aborted) begin
            abort_cnt++;
        end
    end

    task automatic load_byte(input logic [7:0] v);
        slaveDataToSend = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Mode-0 master: CS low, MOSI valid before each rising edge, MISO captured
    // at the rising edge. CS is left low; cs_release ends the transfer.
    task automatic spi_xfer(input logic [15:0] mosi_bits, input int nbits,
                            input int load_at, input logic [7:0] load_val,
                            output logic [15:0] miso_bits, output logic busy_seen);
        miso_bits = '0;
        busy_seen = 1'b0;
        CS = 1'b0;
        MOSI = mosi_bits[nbits-1];
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            SCLK = 1'b1;
            miso_bits = {miso_bits[14:0], miso_w};
            if (i == 2) busy_seen = busy;
            repeat (4) @(negedge clk);
            SCLK = 1'b0;
            if (i + 1 < nbits) MOSI = mosi_bits[nbits-2-i];
            if (i == load_at) begin
                slaveDataToSend = load_val;
                load = 1'b1;
                @(negedge clk);
                load = 1'b0;
                repeat (3) @(negedge clk);
            end else begin
                repeat (4) @(negedge clk);
            end
        end
    endtask

    task automatic cs_release();
        repeat (4) @(negedge clk);
        CS = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] load_val;
        logic [7:0] mosi_val;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation still running at 1 ms, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] miso_bits;
        logic        busy_seen;
        int          d0;
        int          a0;

        vecs[0] = '{8'h09, 8'h53, 8'h09, 8'h53};
        vecs[1] = '{8'h98, 8'h3C, 8'h98, 8'h3C};
        vecs[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
        vecs[3] = '{8'h01, 8'h80, 8'h01, 8'h80};

        reset = 1'b1;
        SCLK = 1'b0;
        CS = 1'b1;
        MOSI = 1'b0;
        load = 1'b0;
        slaveDataToSend = '0;
        repeat (3) @(negedge clk);
        check("reset_rx", {24'h0, slaveDataReceived}, 32'h0);
        check("reset_done", {31'h0, done}, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_aborted", {31'h0, aborted}, 32'h0);
        check("reset_miso_z", {31'h0, miso_w}, 32'h1);
        reset = 1'b0;
        repeat (6) @(negedge clk);

        // Single frames from the table.
        for (int v = 0; v < 4; v++) begin
            d0 = done_cnt;
            load_byte(vecs[v].load_val);
            exp_q.push_back(vecs[v].exp_rx);
            spi_xfer({8'h00, vecs[v].mosi_val}, 8, -1, 8'h00, miso_bits, busy_seen);
            cs_release();
            $display("[TB] frame %0d: load=%02h mosi=%02h miso=%02h rx=%02h",
                     v, vecs[v].load_val, vecs[v].mosi_val, miso_bits[7:0], slaveDataReceived);
            check("miso_byte", {24'h0, miso_bits[7:0]}, {24'h0, vecs[v].exp_miso});
            check("busy_mid", {31'h0, busy_seen}, 32'h1);
            check("done_count", done_cnt - d0, 32'd1);
            check("busy_after", {31'h0, busy}, 32'h0);
            check("miso_released", {31'h0, miso_w}, 32'h1);
            check("rx_hold", {24'h0, slaveDataReceived}, {24'h0, vecs[v].exp_rx});
        end

        // Back-to-back frames with CS held low; new word loaded during byte 1.
        d0 = done_cnt;
        load_byte(8'hA5);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        spi_xfer(16'h1122, 16, 2, 8'h3C, miso_bits, busy_seen);
        cs_release();
        $display("[TB] back-to-back: miso=%04h rx=%02h", miso_bits, slaveDataReceived);
        check("b2b_miso", {16'h0, miso_bits}, 32'h0000A53C);
        check("b2b_done_count", done_cnt - d0, 32'd2);
        check("b2b_rx", {24'h0, slaveDataReceived}, 32'h22);

        // Abort after three rising edges, then a clean frame.
        d0 = done_cnt;
        a0 = abort_cnt;
        load_byte(8'hC3);
        spi_xfer(16'h0007, 3, -1, 8'h00, miso_bits, busy_seen);
        cs_release();
        $display("[TB] abort: aborts=%0d dones=%0d rx=%02h", abort_cnt - a0, done_cnt - d0, slaveDataReceived);
        check("abort_count", abort_cnt - a0, 32'd1);
        check("abort_no_done", done_cnt - d0, 32'd0);
        check("abort_rx_kept", {24'h0, slaveDataReceived}, 32'h22);
        check("abort_busy", {31'h0, busy}, 32'h0);
        d0 = done_cnt;
        exp_q.push_back(8'h7E);
        spi_xfer(16'h007E, 8, -1, 8'h00, miso_bits, busy_seen);
        cs_release();
        $display("[TB] after abort: miso=%02h rx=%02h", miso_bits[7:0], slaveDataReceived);
        check("post_abort_miso", {24'h0, miso_bits[7:0]}, 32'hC3);
        check("post_abort_done", done_cnt - d0, 32'd1);

        // Reset in the middle of a frame with CS still low.
        d0 = done_cnt;
        a0 = abort_cnt;
        load_byte(8'h96);
        spi_xfer(16'h000A, 4, -1, 8'h00, miso_bits, busy_seen);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_rx", {24'h0, slaveDataReceived}, 32'h0);
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_done", {31'h0, done}, 32'h0);
        check("midrst_aborted", {31'h0, aborted}, 32'h0);
        check("midrst_miso_z", {31'h0, miso_w}, 32'h1);
        reset = 1'b0;
        spi_xfer(16'h0005, 4, -1, 8'h00, miso_bits, busy_seen);
        check("midrst_tail_miso_z", {28'h0, miso_bits[3:0]}, 32'hF);
        check("midrst_tail_busy", {31'h0, busy_seen}, 32'h0);
        cs_release();
        $display("[TB] mid-frame reset: dones=%0d aborts=%0d rx=%02h", done_cnt - d0, abort_cnt - a0, slaveDataReceived);
        check("midrst_no_done", done_cnt - d0, 32'd0);
        check("midrst_no_abort", abort_cnt - a0, 32'd0);
        check("midrst_rx_after", {24'h0, slaveDataReceived}, 32'h0);
        d0 = done_cnt;
        load_byte(8'h5A);
        exp_q.push_back(8'h3D);
        spi_xfer(16'h003D, 8, -1, 8'h00, miso_bits, busy_seen);
        cs_release();
        $display("[TB] after reset: miso=%02h rx=%02h", miso_bits[7:0], slaveDataReceived);
        check("post_rst_miso", {24'h0, miso_bits[7:0]}, 32'h5A);
        check("post_rst_done", done_cnt - d0, 32'd1);
        check("post_rst_rx", {24'h0, slaveDataReceived}, 32'h3D);

        // CS high throughout: SCLK/MOSI activity must be ignored.
        d0 = done_cnt;
        a0 = abort_cnt;
        CS = 1'b1;
        for (int i = 0; i < 6; i++) begin
            MOSI = i[0];
            SCLK = 1'b1;
            repeat (4) @(negedge clk);
            check("idle_miso_z", {31'h0, miso_w}, 32'h1);
            SCLK = 1'b0;
            repeat (4) @(negedge clk);
        end
        $display("[TB] idle: dones=%0d aborts=%0d", done_cnt - d0, abort_cnt - a0);
        check("idle_no_done", done_cnt - d0, 32'd0);
        check("idle_no_abort", abort_cnt - a0, 32'd0);
        check("idle_busy", {31'h0, busy}, 32'h0);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
